// File: rtl/conv1_col_scheduler.sv
// conv1_col_scheduler: streams one frame of columns from the input column buffer
// into the first convolution layer, counts returned fm/pool columns, reports done
// and flags a drain timeout.
// Optional feature macro: CONV1_SCHED_PERF_EN adds frame_cycles[31:0]
// (cycles from accepted start through done, inclusive).
module conv1_col_scheduler #(
    parameter int unsigned DATA_WIDTH           = 16,
    parameter int unsigned INPUT_COL_SIZE       = 12,
    parameter int unsigned INPUT_CHANNEL_NUMBER = 4,
    parameter int unsigned KERNEL_SIZE          = 3,
    parameter int unsigned NUM_COLS             = 12,
    parameter int unsigned WARMUP_CYCLES        = 4,
    parameter int unsigned COL_GAP              = 1,
    parameter int unsigned DRAIN_TIMEOUT        = 64,
    localparam int unsigned COL_W  = INPUT_CHANNEL_NUMBER * INPUT_COL_SIZE * DATA_WIDTH,
    localparam int unsigned ADDR_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [COL_W-1:0]  rd_data,
    output logic              conv_valid_in,
    output logic [COL_W-1:0]  conv_cols,
    input  logic              conv_column_valid,
    input  logic              conv_valid_out
`ifdef CONV1_SCHED_PERF_EN
    ,
    output logic [31:0]       frame_cycles
`endif
);

    localparam int unsigned IDX_W     = $clog2(NUM_COLS + 1);
    localparam int unsigned CNT_W     = IDX_W;
    localparam int unsigned FM_COLS   = NUM_COLS - KERNEL_SIZE + 1;
    localparam int unsigned POOL_COLS = FM_COLS / 2;
    localparam int unsigned WARM_W    = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam int unsigned GAP_W     = (COL_GAP > 0) ? $clog2(COL_GAP + 1) : 1;
    localparam int unsigned DRN_W     = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  FM_TGT    = CNT_W'(FM_COLS);
    localparam logic [CNT_W-1:0]  POOL_TGT  = CNT_W'(POOL_COLS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_COLS - 1);
    localparam logic [IDX_W-1:0]  END_IDX   = IDX_W'(NUM_COLS);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((COL_GAP > 0) ? COL_GAP - 1 : 0);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_WARMUP,
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic              pending;
    logic [WARM_W-1:0] warm_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DRN_W-1:0]  drain_cnt;
    logic [IDX_W-1:0]  col_idx;
    logic [CNT_W-1:0]  fm_cnt;
    logic [CNT_W-1:0]  pool_cnt;

    // Frame sequencer: state, column/fm/pool counters and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_WARMUP;
            pending       <= 1'b0;
            warm_cnt      <= '0;
            gap_cnt       <= '0;
            drain_cnt     <= '0;
            col_idx       <= '0;
            fm_cnt        <= '0;
            pool_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            conv_valid_in <= 1'b0;
            conv_cols     <= '0;
        end else begin
            done          <= 1'b0;
            rd_en         <= 1'b0;
            conv_valid_in <= 1'b0;

            // Layer outputs are only counted inside a frame; saturate instead of wrapping
            if (busy && conv_column_valid && (fm_cnt != CNT_MAX)) begin
                fm_cnt <= fm_cnt + CNT_W'(1);
            end
            if (busy && conv_valid_out && (pool_cnt != CNT_MAX)) begin
                pool_cnt <= pool_cnt + CNT_W'(1);
            end

            case (state)
                S_WARMUP: begin
                    if (start) begin
                        pending <= 1'b1;
                    end
                    if (warm_cnt == WARM_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                end

                S_IDLE: begin
                    if (start || pending) begin
                        pending  <= 1'b0;
                        col_idx  <= '0;
                        fm_cnt   <= '0;
                        pool_cnt <= '0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        state    <= S_FETCH;
                    end
                end

                // rd_data for rd_addr arrives during ISSUE (1-cycle buffer latency)
                S_FETCH: begin
                    state <= S_ISSUE;
                end

                S_ISSUE: begin
                    conv_cols     <= rd_data;
                    conv_valid_in <= 1'b1;
                    col_idx       <= col_idx + IDX_W'(1);
                    gap_cnt       <= '0;
                    drain_cnt     <= '0;
                    if (COL_GAP > 0) begin
                        state <= S_GAP;
                    end else if (col_idx == LAST_IDX) begin
                        state <= S_DRAIN;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= ADDR_W'(col_idx + IDX_W'(1));
                        state   <= S_FETCH;
                    end
                end

                S_GAP: begin
                    drain_cnt <= '0;
                    if (gap_cnt == GAP_LAST) begin
                        if (col_idx != END_IDX) begin
                            rd_en   <= 1'b1;
                            rd_addr <= ADDR_W'(col_idx);
                            state   <= S_FETCH;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                // Wait for all expected layer outputs, bounded by the drain timer
                S_DRAIN: begin
                    if ((fm_cnt == FM_TGT) && (pool_cnt == POOL_TGT)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (drain_cnt == DRN_LAST) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_WARMUP;
                end
            endcase
        end
    end

`ifdef CONV1_SCHED_PERF_EN
    // Frame length: 1 on the accepting cycle, then +1 for every in-frame cycle through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cycles <= '0;
        end else if ((state == S_IDLE) && (start || pending)) begin
            frame_cycles <= 32'd1;
        end else if ((state != S_IDLE) && (state != S_WARMUP)) begin
            frame_cycles <= frame_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv1_col_scheduler.sv
// Testbench for conv1_col_scheduler: two instances (COL_GAP=1 and COL_GAP=0) share a
// column-buffer model and a randomized layer model; results are checked against
// timing/ordering rules computed here from the frame-level behaviour.
module tb_conv1_col_scheduler;

    localparam int unsigned DW    = 16;
    localparam int unsigned ROWS  = 12;
    localparam int unsigned CH    = 4;
    localparam int unsigned K     = 3;
    localparam int unsigned NC    = 12;
    localparam int unsigned WU    = 4;
    localparam int unsigned TO    = 64;
    localparam int unsigned COL_W = DW * ROWS * CH;
    localparam int unsigned AW    = $clog2(NC);
    localparam int FM_COLS   = NC - K + 1;
    localparam int POOL_COLS = FM_COLS / 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    int               sel = 0;
    logic [COL_W-1:0] rd_data = '0;
    logic             conv_column_valid = 1'b0;
    logic             conv_valid_out = 1'b0;

    logic g1_busy, g1_done, g1_error, g1_rd_en, g1_valid;
    logic g0_busy, g0_done, g0_error, g0_rd_en, g0_valid;
    logic [AW-1:0]    g1_rd_addr, g0_rd_addr;
    logic [COL_W-1:0] g1_cols, g0_cols;
`ifdef CONV1_SCHED_PERF_EN
    logic [31:0] g1_fc, g0_fc;
`endif

    logic             m_busy, m_done, m_error, m_rd_en, m_valid;
    logic [AW-1:0]    m_rd_addr;
    logic [COL_W-1:0] m_cols;

    conv1_col_scheduler #(.COL_GAP(1)) u_g1 (
        .clk(clk), .rst(rst), .start(start && (sel == 0)),
        .busy(g1_busy), .done(g1_done), .error(g1_error),
        .rd_en(g1_rd_en), .rd_addr(g1_rd_addr), .rd_data(rd_data),
        .conv_valid_in(g1_valid), .conv_cols(g1_cols),
        .conv_column_valid(conv_column_valid), .conv_valid_out(conv_valid_out)
`ifdef CONV1_SCHED_PERF_EN
        , .frame_cycles(g1_fc)
`endif
    );

    conv1_col_scheduler #(.COL_GAP(0)) u_g0 (
        .clk(clk), .rst(rst), .start(start && (sel == 1)),
        .busy(g0_busy), .done(g0_done), .error(g0_error),
        .rd_en(g0_rd_en), .rd_addr(g0_rd_addr), .rd_data(rd_data),
        .conv_valid_in(g0_valid), .conv_cols(g0_cols),
        .conv_column_valid(conv_column_valid), .conv_valid_out(conv_valid_out)
`ifdef CONV1_SCHED_PERF_EN
        , .frame_cycles(g0_fc)
`endif
    );

    assign m_busy    = (sel == 1) ? g0_busy    : g1_busy;
    assign m_done    = (sel == 1) ? g0_done    : g1_done;
    assign m_error   = (sel == 1) ? g0_error   : g1_error;
    assign m_rd_en   = (sel == 1) ? g0_rd_en   : g1_rd_en;
    assign m_rd_addr = (sel == 1) ? g0_rd_addr : g1_rd_addr;
    assign m_valid   = (sel == 1) ? g0_valid   : g1_valid;
    assign m_cols    = (sel == 1) ? g0_cols    : g1_cols;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Column buffer: synchronous read, one cycle latency
    logic [COL_W-1:0] mem [NC];
    always @(posedge clk) if (m_rd_en) rd_data <= mem[m_rd_addr];

    int               checks = 0;
    int               errors = 0;
    int               iss_cyc[$];
    logic [COL_W-1:0] iss_data[$];
    int               addr_q[$];
    int               done_cyc[$];
    logic             done_err[$];
    int               fmq[$];
    int               poolq[$];
    int               n_issued = 0;
    int               fm_made = 0;
    int               last_pulse = 0;
    bit               withhold = 1'b0;
    int               dur_g1 = 0;

    // Monitor plus layer model: one fm column per issued column from the K-th on,
    // one pool column per two fm columns, each delayed by a random lag
    always @(negedge clk) begin
        int lag;
        conv_column_valid = 1'b0;
        conv_valid_out    = 1'b0;
        if (rst) begin
            fmq.delete();
            poolq.delete();
            n_issued = 0;
            fm_made  = 0;
        end else begin
            if (m_valid) begin
                iss_cyc.push_back(cyc);
                iss_data.push_back(m_cols);
                n_issued++;
                if (n_issued >= int'(K)) begin
                    lag = int'($urandom_range(0, 3));
                    fm_made++;
                    fmq.push_back(cyc + lag);
                    if ((fm_made % 2 == 0) && !(withhold && (fm_made / 2 == POOL_COLS)))
                        poolq.push_back(cyc + lag + 1);
                end
            end
            if (m_rd_en) addr_q.push_back(int'(m_rd_addr));
            if (m_done) begin
                done_cyc.push_back(cyc);
                done_err.push_back(m_error);
            end
            if (fmq.size() > 0 && fmq[0] <= cyc) begin
                conv_column_valid = 1'b1;
                void'(fmq.pop_front());
                last_pulse = cyc;
            end
            if (poolq.size() > 0 && poolq[0] <= cyc) begin
                conv_valid_out = 1'b1;
                void'(poolq.pop_front());
                last_pulse = cyc;
            end
        end
    end

    task automatic fill_mem();
        for (int c = 0; c < int'(NC); c++)
            for (int w = 0; w < int'(COL_W / 32); w++)
                mem[c][w*32 +: 32] = $urandom();
    endtask

    task automatic clear_obs();
        iss_cyc.delete();
        iss_data.delete();
        addr_q.delete();
        done_cyc.delete();
        done_err.delete();
        n_issued   = 0;
        fm_made    = 0;
        last_pulse = 0;
    endtask

    // Stimulus only: pulse start, optionally re-pulse it after mid_col issues, wait for done
    task automatic run_frame(input int mid_col, output bit ok, output int st_cyc);
        bit mid_sent;
        mid_sent = 1'b0;
        ok = 1'b0;
        fill_mem();
        @(negedge clk);
        clear_obs();
        start  = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mid_col > 0 && !mid_sent && iss_cyc.size() == mid_col) begin
                start    = 1'b1;
                mid_sent = 1'b1;
            end
            if (done_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", m_busy); end
        checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", m_done); end
        checks++; if (m_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", m_error); end
        checks++; if (m_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", m_rd_en); end
        checks++; if (m_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", m_rd_addr); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++; if (m_cols !== '0) begin errors++; $display("FAIL reset_cols got=%h exp=0", m_cols); end
    endtask

    task automatic test_pending_start();
        int r;
        bit ok;
        sel = 0;
        fill_mem();
        clear_obs();
        rst = 1'b0;
        r = cyc;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done_cyc.size() > 0) begin ok = 1'b1; break; end
        end
        repeat (8) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL pending_done got=none exp=done within budget"); end
        checks++;
        if (iss_cyc.size() == 0 || iss_cyc[0] - r < int'(WU) + 2) begin
            errors++;
            $display("FAIL pending_first_issue got=%0d exp>=%0d", (iss_cyc.size() > 0) ? iss_cyc[0] - r : -1, WU + 2);
        end
        checks++; if (iss_cyc.size() != int'(NC)) begin errors++; $display("FAIL pending_issues got=%0d exp=%0d", iss_cyc.size(), NC); end
    endtask

    task automatic test_frame(input int s, input int g);
        bit ok;
        int st, exp_done, d_ent;
        sel = s;
        run_frame(0, ok, st);
        checks++; if (!ok) begin errors++; $display("FAIL g%0d_done_seen got=none exp=done within budget", g); end
        checks++; if (iss_cyc.size() != int'(NC)) begin errors++; $display("FAIL g%0d_issue_count got=%0d exp=%0d", g, iss_cyc.size(), NC); end
        checks++; if (addr_q.size() != int'(NC)) begin errors++; $display("FAIL g%0d_rd_count got=%0d exp=%0d", g, addr_q.size(), NC); end
        for (int i = 0; i < addr_q.size() && i < int'(NC); i++) begin
            checks++; if (addr_q[i] != i) begin errors++; $display("FAIL g%0d_rd_addr[%0d] got=%0d exp=%0d", g, i, addr_q[i], i); end
        end
        for (int i = 0; i < iss_data.size() && i < int'(NC); i++) begin
            checks++; if (iss_data[i] !== mem[i]) begin errors++; $display("FAIL g%0d_cols[%0d] got=%h exp=%h", g, i, iss_data[i], mem[i]); end
        end
        for (int i = 1; i < iss_cyc.size(); i++) begin
            checks++; if (iss_cyc[i] - iss_cyc[i-1] != 2 + g) begin errors++; $display("FAIL g%0d_spacing[%0d] got=%0d exp=%0d", g, i, iss_cyc[i] - iss_cyc[i-1], 2 + g); end
        end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL g%0d_done_count got=%0d exp=1", g, done_cyc.size()); end
        if (done_cyc.size() > 0 && iss_cyc.size() > 0) begin
            d_ent    = iss_cyc[iss_cyc.size()-1] + g;
            exp_done = ((d_ent > last_pulse + 1) ? d_ent : last_pulse + 1) + 1;
            checks++; if (done_cyc[0] != exp_done) begin errors++; $display("FAIL g%0d_done_time got=%0d exp=%0d", g, done_cyc[0], exp_done); end
            checks++; if (done_err[0] !== 1'b0) begin errors++; $display("FAIL g%0d_done_error got=%b exp=0", g, done_err[0]); end
            if (g == 1) dur_g1 = done_cyc[0] - st;
            else begin
                checks++; if (done_cyc[0] - st >= dur_g1) begin errors++; $display("FAIL g0_shorter got=%0d exp<%0d", done_cyc[0] - st, dur_g1); end
            end
`ifdef CONV1_SCHED_PERF_EN
            checks++;
            if (((g == 1) ? g1_fc : g0_fc) !== 32'(done_cyc[0] - st + 1)) begin
                errors++; $display("FAIL g%0d_frame_cycles got=%0d exp=%0d", g, (g == 1) ? g1_fc : g0_fc, done_cyc[0] - st + 1);
            end
`endif
        end
        checks++; if (m_cols !== mem[NC-1]) begin errors++; $display("FAIL g%0d_cols_hold got=%h exp=%h", g, m_cols, mem[NC-1]); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL g%0d_busy_after got=%b exp=0", g, m_busy); end
    endtask

    task automatic test_timeout();
        bit ok;
        int st, d_ent;
        sel = 0;
        withhold = 1'b1;
        run_frame(0, ok, st);
        withhold = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL to_done_seen got=none exp=done within budget"); end
        if (done_cyc.size() > 0 && iss_cyc.size() > 0) begin
            d_ent = iss_cyc[iss_cyc.size()-1] + 1;
            checks++; if (done_cyc[0] - d_ent != int'(TO)) begin errors++; $display("FAIL to_done_time got=%0d exp=%0d", done_cyc[0] - d_ent, TO); end
            checks++; if (done_err[0] !== 1'b1) begin errors++; $display("FAIL to_error_at_done got=%b exp=1", done_err[0]); end
        end
        checks++; if (m_error !== 1'b1) begin errors++; $display("FAIL to_error_sticky got=%b exp=1", m_error); end
        // Next accepted start must clear the flag
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (m_error !== 1'b0) begin errors++; $display("FAIL to_error_clear got=%b exp=0", m_error); end
        for (int i = 0; i < 2000 && m_busy; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_start_mid_frame();
        bit ok;
        int st;
        sel = 0;
        run_frame(5, ok, st);
        checks++; if (!ok) begin errors++; $display("FAIL mid_done_seen got=none exp=done within budget"); end
        checks++; if (iss_cyc.size() != int'(NC)) begin errors++; $display("FAIL mid_issue_count got=%0d exp=%0d", iss_cyc.size(), NC); end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL mid_done_count got=%0d exp=1", done_cyc.size()); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok, hit;
        int st, r;
        sel = 0;
        fill_mem();
        @(negedge clk);
        clear_obs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (iss_cyc.size() >= 7) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach got=%0d exp=7 issues", iss_cyc.size()); end
        rst = 1'b1;
        #1;
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", m_busy); end
        checks++; if (m_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_en got=%b exp=0", m_rd_en); end
        checks++; if (m_rd_addr !== '0) begin errors++; $display("FAIL rst_mid_rd_addr got=%0d exp=0", m_rd_addr); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", m_valid); end
        checks++; if (m_cols !== '0) begin errors++; $display("FAIL rst_mid_cols got=%h exp=0", m_cols); end
        checks++; if (m_done !== 1'b0 || m_error !== 1'b0) begin errors++; $display("FAIL rst_mid_done_err got=%b%b exp=00", m_done, m_error); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r = cyc;
        repeat (WU + 2) @(negedge clk);
        run_frame(0, ok, st);
        checks++; if (!ok) begin errors++; $display("FAIL rst_replay_done got=none exp=done within budget"); end
        checks++; if (addr_q.size() == 0 || addr_q[0] != 0) begin errors++; $display("FAIL rst_replay_addr0 got=%0d exp=0", (addr_q.size() > 0) ? addr_q[0] : -1); end
        checks++; if (iss_cyc.size() != int'(NC)) begin errors++; $display("FAIL rst_replay_issues got=%0d exp=%0d", iss_cyc.size(), NC); end
        for (int i = 0; i < iss_data.size() && i < int'(NC); i++) begin
            checks++; if (iss_data[i] !== mem[i]) begin errors++; $display("FAIL rst_replay_cols[%0d] got=%h exp=%h", i, iss_data[i], mem[i]); end
        end
        checks++; if (iss_cyc.size() > 0 && iss_cyc[0] - r < int'(WU) + 2) begin errors++; $display("FAIL rst_replay_warmup got=%0d exp>=%0d", iss_cyc[0] - r, WU + 2); end
    endtask

    initial begin
        test_reset();
        test_pending_start();
        test_frame(0, 1);
        test_frame(1, 0);
        test_frame(0, 1);
        test_timeout();
        test_start_mid_frame();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
